// File: rtl/serial_adder_ctrl.sv
// Serial adder controller: adds two WIDTH-bit operands LSB first through one shared 1-bit full adder.
// Optional two's-complement overflow output is enabled with SERIAL_ADDER_CTRL_OVF_EN.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_CTRL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic [WIDTH-1:0]   sum_sh_r;
    logic               carry_r;
    logic [CW-1:0]      cnt_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               ovf_r;
    logic               fa_sum_s;
    logic               fa_cout_s;

    full_Adder u_fa (
        .A    (a_sh_r[0]),
        .B    (b_sh_r[0]),
        .Cin  (carry_r),
        .S    (fa_sum_s),
        .Cout (fa_cout_s)
    );

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;
`ifdef SERIAL_ADDER_CTRL_OVF_EN
    assign ovf  = ovf_r;
`endif

    // Sequencer: accepts a start, steps one bit per clock, publishes the result on the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            a_sh_r   <= '0;
            b_sh_r   <= '0;
            sum_sh_r <= '0;
            carry_r  <= 1'b0;
            cnt_r    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            sum_r    <= '0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_sh_r   <= a;
                        b_sh_r   <= b;
                        carry_r  <= cin;
                        sum_sh_r <= '0;
                        cnt_r    <= '0;
                        busy_r   <= 1'b1;
                        state_r  <= RUN;
                    end else begin
                        busy_r   <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                RUN: begin
                    sum_sh_r <= {fa_sum_s, sum_sh_r[WIDTH-1:1]};
                    carry_r  <= fa_cout_s;
                    a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
                    cnt_r    <= cnt_r + CW'(1);
                    if (cnt_r == LAST) begin
                        // carry_r here is the carry into the MSB, so overflow compares it with the carry out
                        sum_r   <= {fa_sum_s, sum_sh_r[WIDTH-1:1]};
                        cout_r  <= fa_cout_s;
                        ovf_r   <= carry_r ^ fa_cout_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= RUN;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// Single-bit full adder shared by every step of the serial addition.
module full_Adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): vector table, scoreboard queue, handshake corner cases.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_CTRL_OVF_EN
    logic         ovf;
`endif

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_CTRL_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Independent arithmetic model for randomly generated vectors.
    function automatic vec_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        vec_t     v;
        logic [W:0] t;
        t      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        v.a    = x;
        v.b    = y;
        v.cin  = c;
        v.sum  = t[W-1:0];
        v.cout = t[W];
        v.ovf  = (x[W-1] ~^ y[W-1]) & (t[W-1] ^ x[W-1]);
        return v;
    endfunction

    task automatic start_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                             input logic [W-1:0] es, input logic ec, input logic eo);
        exp_t e;
        @(posedge clk); #1;
        a = x; b = y; cin = c; start = 1'b1;
        e.sum = es; e.cout = ec; e.ovf = eo;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    // Advances at least one edge, then until done or the budget expires; scores the result.
    task automatic wait_done(input int max, output int n);
        exp_t e;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (done !== 1'b1 && n < max);
        if (done !== 1'b1) begin
            check("done_timeout", 32'(done), 32'd1);
        end else begin
            check("busy_done_excl", 32'(busy), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sum", 32'(sum), 32'(e.sum));
                check("cout", 32'(cout), 32'(e.cout));
`ifdef SERIAL_ADDER_CTRL_OVF_EN
                check("ovf", 32'(ovf), 32'(e.ovf));
`endif
            end
        end
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) cnt++;
        end
    endtask

    initial begin
        int n;
        int extra;

        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0};
        vecs[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        for (int i = 7; i < 10; i++)
            vecs[i] = model(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            start_add(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].ovf);
            wait_done(20, n);
            check("latency", 32'(n), 32'd8);
            @(posedge clk); #1;
            check("done_one_cycle", 32'(done), 32'd0);
        end

        // start held high: back-to-back results every 9 cycles; operand change mid-run is ignored
        @(posedge clk); #1;
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        sb.push_back('{8'h02, 1'b0, 1'b0});
        wait_done(20, n);
        check("held_first_latency", 32'(n), 32'd9);
        sb.push_back('{8'h02, 1'b0, 1'b0});
        repeat (4) @(posedge clk);
        #1;
        a = 8'h10; start = 1'b0;
        wait_done(20, n);
        check("held_period", 32'(n + 4), 32'd9);
        @(posedge clk); #1;
        check("held_idle_busy", 32'(busy), 32'd0);

        // start during busy with new operands is ignored
        start_add(8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(20, n);
        check("ignored_start_latency", 32'(n), 32'd4);
        count_dones(15, extra);
        check("no_extra_done", 32'(extra), 32'd0);

        // asynchronous reset between edges mid-run
        start_add(8'h55, 8'h66, 1'b0, 8'hBB, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_sum", 32'(sum), 32'd0);
        check("arst_cout", 32'(cout), 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        count_dones(12, extra);
        check("arst_no_done", 32'(extra), 32'd0);
        start_add(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
        wait_done(20, n);
        check("arst_fresh_latency", 32'(n), 32'd8);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
